// File: rtl/demux1_2_pingpong.sv
// 1-to-2 valid/ready stream demultiplexer with a one-entry register slice per channel.
// The target is either an external select or a ping-pong bank that flips every BLOCK_LEN beats.
module demux1_2_pingpong #(
  parameter int DATA_WIDTH = 16,
  parameter int BLOCK_LEN  = 28,
  parameter int CNT_W      = $clog2(BLOCK_LEN)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mode,
  input  logic                  sel,
  input  logic                  restart,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out0_valid,
  input  logic                  out0_ready,
  output logic [DATA_WIDTH-1:0] out0_data,
  output logic                  out1_valid,
  input  logic                  out1_ready,
  output logic [DATA_WIDTH-1:0] out1_data,
  output logic                  bank,
  output logic                  block_done
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(BLOCK_LEN - 1);

  logic                  out0_valid_q, out0_valid_d;
  logic                  out1_valid_q, out1_valid_d;
  logic [DATA_WIDTH-1:0] out0_data_q, out0_data_d;
  logic [DATA_WIDTH-1:0] out1_data_q, out1_data_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  bank_q, bank_d;
  logic                  done_q, done_d;

  logic tgt;
  logic accept;
  logic load0, load1;

  assign tgt      = mode ? bank_q : sel;
  assign in_ready = tgt ? (!out1_valid_q || out1_ready) : (!out0_valid_q || out0_ready);
  assign accept   = in_valid && in_ready;
  assign load0    = accept && !tgt;
  assign load1    = accept && tgt;

  // A load wins over a drain on the same edge, so a full slice refills without a bubble.
  always_comb begin
    out0_valid_d = out0_valid_q;
    out0_data_d  = out0_data_q;
    out1_valid_d = out1_valid_q;
    out1_data_d  = out1_data_q;
    if (load0) begin
      out0_valid_d = 1'b1;
      out0_data_d  = in_data;
    end else if (out0_ready) begin
      out0_valid_d = 1'b0;
    end
    if (load1) begin
      out1_valid_d = 1'b1;
      out1_data_d  = in_data;
    end else if (out1_ready) begin
      out1_valid_d = 1'b0;
    end
  end

  // restart overrides any count update; the beat itself was already steered by the old bank.
  always_comb begin
    cnt_d  = cnt_q;
    bank_d = bank_q;
    done_d = 1'b0;
    if (restart) begin
      cnt_d  = '0;
      bank_d = 1'b0;
    end else if (accept && mode) begin
      if (cnt_q == LAST) begin
        cnt_d  = '0;
        bank_d = ~bank_q;
        done_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out0_valid_q <= 1'b0;
      out1_valid_q <= 1'b0;
      out0_data_q  <= '0;
      out1_data_q  <= '0;
      cnt_q        <= '0;
      bank_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      out0_valid_q <= out0_valid_d;
      out1_valid_q <= out1_valid_d;
      out0_data_q  <= out0_data_d;
      out1_data_q  <= out1_data_d;
      cnt_q        <= cnt_d;
      bank_q       <= bank_d;
      done_q       <= done_d;
    end
  end

  assign out0_valid = out0_valid_q;
  assign out1_valid = out1_valid_q;
  assign out0_data  = out0_data_q;
  assign out1_data  = out1_data_q;
  assign bank       = bank_q;
  assign block_done = done_q;

endmodule

// File: tb/tb_demux1_2_pingpong.sv
// Directed plus randomized bench for demux1_2_pingpong, checked against a beat-count reference model.
module tb_demux1_2_pingpong;

  localparam int DW = 16;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          mode = 1'b0;
  logic          sel = 1'b0;
  logic          restart = 1'b0;
  logic          in_valid = 1'b0;
  logic          out0_ready = 1'b0;
  logic          out1_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out0_valid, out1_valid;
  logic [DW-1:0] out0_data, out1_data;
  logic          bank, block_done;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: total ping-pong beats since restart/reset, plus one slot per channel.
  int unsigned   pp;
  logic          mv[2];
  logic [DW-1:0] md[2];
  logic          mdone;
  logic          cur_mode;

  always #5 clk = ~clk;

  demux1_2_pingpong #(.DATA_WIDTH(DW), .BLOCK_LEN(BL)) dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .sel(sel), .restart(restart),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out0_valid(out0_valid), .out0_ready(out0_ready), .out0_data(out0_data),
    .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
    .bank(bank), .block_done(block_done)
  );

  function automatic logic m_bank();
    return ((pp / BL) % 2) == 1;
  endfunction

  task automatic model_reset();
    pp = 0; mv[0] = 1'b0; mv[1] = 1'b0; md[0] = '0; md[1] = '0; mdone = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, ".out0_valid"}, 32'(out0_valid), 32'(mv[0]));
    chk({tag, ".out0_data"},  32'(out0_data),  32'(md[0]));
    chk({tag, ".out1_valid"}, 32'(out1_valid), 32'(mv[1]));
    chk({tag, ".out1_data"},  32'(out1_data),  32'(md[1]));
    chk({tag, ".bank"},       32'(bank),       32'(m_bank()));
    chk({tag, ".block_done"}, 32'(block_done), 32'(mdone));
  endtask

  // Called 1 time unit after a rising edge; returns 1 time unit after the next one.
  task automatic step(input string tag, input logic v, input logic [DW-1:0] d, input logic s,
                      input logic m, input logic r0, input logic r1, input logic rs);
    int  ti;
    logic exp_rdy, acc;
    in_valid = v; in_data = d; sel = s; mode = m;
    out0_ready = r0; out1_ready = r1; restart = rs;
    #4;
    ti = (m ? m_bank() : s) ? 1 : 0;
    exp_rdy = !mv[ti] || (ti == 1 ? r1 : r0);
    chk({tag, ".in_ready"}, 32'(in_ready), 32'(exp_rdy));
    acc = v && exp_rdy;
    @(posedge clk); #1;
    if (mv[0] && r0) mv[0] = 1'b0;
    if (mv[1] && r1) mv[1] = 1'b0;
    if (acc) begin mv[ti] = 1'b1; md[ti] = d; end
    mdone = 1'b0;
    if (rs) pp = 0;
    else if (acc && m) begin
      pp++;
      if (pp % BL == 0) mdone = 1'b1;
    end
    check_outs(tag);
    in_valid = 1'b0; restart = 1'b0;
    cur_mode = m;
  endtask

  task automatic async_reset_mid_cycle();
    rst_n = 1'b0;
    #2;
    model_reset();
    check_outs("async_rst");
    @(posedge clk); #1;
    check_outs("async_rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    logic        v, s, m, r0, r1, rs;
    logic [DW-1:0] d;
    model_reset();
    cur_mode = 1'b0;

    // Reset held with a live input beat: nothing may be captured.
    in_valid = 1'b1; in_data = 16'hABCD; out0_ready = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
      check_outs("reset_hold");
    end
    rst_n = 1'b1;
    step("rst_release", 1'b1, 16'hABCD, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rst_release.direct_data", 32'(out0_data), 32'h0000ABCD);

    // Static steering 1,2,3,4 with sel 0,1,1,0.
    step("static1", 1'b1, 16'd1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("static2", 1'b1, 16'd2, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("static3", 1'b1, 16'd3, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    step("static4", 1'b1, 16'd4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("static.direct_ch0", 32'(out0_data), 32'd4);
    chk("static.direct_ch1", 32'(out1_data), 32'd3);
    step("static_idle", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Ping-pong: 10 continuous beats.
    step("pp_mode", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++)
      step("pingpong", 1'b1, 16'(i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("pp_idle", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Backpressure on channel 0, then refill on the releasing edge.
    step("bp_mode", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    step("bp_load5", 1'b1, 16'd5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("bp_stall", 1'b1, 16'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step("bp_stall", 1'b1, 16'd6, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("bp.direct_held", 32'(out0_data), 32'd5);
    step("bp_refill", 1'b1, 16'd6, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("bp.direct_refill", 32'(out0_data), 32'd6);
    step("bp_drain", 1'b0, 16'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);

    // Restart mid-block.
    step("rs_mode", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("rs_pre", 1'b1, 16'h10, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("rs_pre", 1'b1, 16'h11, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    step("restart", 1'b0, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 4; i++)
      step("rs_post", 1'b1, 16'(16'h20 + i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("restart.direct_done", 32'(block_done), 32'd1);

    // Asynchronous reset between edges, mid-block.
    step("ar_pre", 1'b1, 16'h30, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("ar_pre", 1'b1, 16'h31, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    async_reset_mid_cycle();
    for (int i = 0; i < 4; i++)
      step("ar_post", 1'b1, 16'(16'h40 + i), 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized traffic; a mode change only happens on an idle cycle.
    for (int i = 0; i < 400; i++) begin
      m  = ($urandom_range(0, 9) == 0) ? ~cur_mode : cur_mode;
      v  = (m != cur_mode) ? 1'b0 : ($urandom_range(0, 3) != 0);
      d  = DW'($urandom);
      s  = 1'($urandom);
      r0 = ($urandom_range(0, 9) < 7);
      r1 = ($urandom_range(0, 9) < 7);
      rs = ($urandom_range(0, 29) == 0);
      step("random", v, d, s, m, r0, r1, rs);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
